// File: rtl/fusion_sa_pkg.sv
// Shared definitions for the fusion systolic array: precision codes, FSM states
// and the operand extension used for both inputs and weights.
package fusion_sa_pkg;

  localparam logic [1:0] WID_2B = 2'd0;
  localparam logic [1:0] WID_4B = 2'd1;
  localparam logic [1:0] WID_8B = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // Code 3 falls into the default arm and behaves as 8-bit.
  function automatic logic signed [8:0] ext_operand(input logic [7:0] b,
                                                    input logic [1:0] code,
                                                    input logic       is_signed);
    logic signed [8:0] v;
    case (code)
      WID_2B:  v = {{7{is_signed & b[1]}}, b[1:0]};
      WID_4B:  v = {{5{is_signed & b[3]}}, b[3:0]};
      default: v = {is_signed & b[7], b};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fusion_pe.sv
// Weight-stationary processing element: holds one extended weight, multiplies the
// passing input and adds it to the partial sum arriving from the row above.
module fusion_pe #(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    w_load_i,
  input  logic signed [8:0]       w_i,
  input  logic signed [8:0]       x_i,
  input  logic        [ACC_W-1:0] psum_i,
  output logic signed [8:0]       x_o,
  output logic        [ACC_W-1:0] psum_o
);

  logic signed [8:0]       w_q;
  logic signed [8:0]       x_q;
  logic        [ACC_W-1:0] psum_q;
  logic signed [17:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = 18'(x_i) * 18'(w_q);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      x_q    <= '0;
      psum_q <= '0;
    end else begin
      if (w_load_i) w_q <= w_i;
      if (en_i) begin
        x_q    <= x_i;
        psum_q <= psum_i + prod_ext;
      end
    end
  end

  assign x_o    = x_q;
  assign psum_o = psum_q;

endmodule

// File: rtl/fusion_systolic_array.sv
// Weight-stationary ROWSxCOLS matrix-vector engine with configurable operand
// precision, input skew / output deskew and a single global stall.
module fusion_systolic_array
  import fusion_sa_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cfg_in_width,
  input  logic [1:0]              cfg_weight_width,
  input  logic                    cfg_s_in,
  input  logic                    cfg_s_weight,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [ROWS*COLS*8-1:0]  w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*8-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_psum,
  output logic                    busy
);

  // Valid stages ahead of the output register; with the output register the
  // total matches the ROWS+COLS cycle latency.
  localparam int VDEPTH = ROWS + COLS - 1;

  state_e                 state_q;
  logic [1:0]             cfg_in_w_q;
  logic                   cfg_s_in_q;
  logic [VDEPTH-1:0]      vld_q;
  logic                   out_valid_q;
  logic [COLS*ACC_W-1:0]  out_psum_q;
  logic [COLS*ACC_W-1:0]  out_psum_d;

  logic stall, en, w_fire, in_fire;

  assign stall    = out_valid_q && !out_ready;
  assign en       = !stall;
  assign w_ready  = (state_q == ST_IDLE);
  assign in_ready = (state_q == ST_STREAM) && !stall;
  assign busy     = (state_q != ST_IDLE);
  assign w_fire   = w_valid && w_ready;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cfg_in_w_q <= WID_8B;
      cfg_s_in_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_fire) begin
            state_q    <= ST_STREAM;
            cfg_in_w_q <= cfg_in_width;
            cfg_s_in_q <= cfg_s_in;
          end
        end
        ST_STREAM: begin
          if (in_fire && in_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready && (vld_q == '0)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
    end else if (en) begin
      vld_q       <= {vld_q[VDEPTH-2:0], in_fire};
      out_valid_q <= vld_q[VDEPTH-1];
      out_psum_q  <= out_psum_d;
    end
  end

  logic signed [8:0]       x_ext [ROWS];
  logic signed [8:0]       xg    [ROWS][COLS+1];
  logic        [ACC_W-1:0] pg    [ROWS+1][COLS];

  // Row r enters r cycles late so that its operand meets the partial sum
  // coming down from row r-1 of the same vector.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign x_ext[r] = ext_operand(in_data[r*8 +: 8], cfg_in_w_q, cfg_s_in_q);
    if (r == 0) begin : g_noskew
      assign xg[0][0] = x_ext[0];
    end else begin : g_skew
      logic signed [8:0] sk_q [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else if (en) begin
          sk_q[0] <= x_ext[r];
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign xg[r][0] = sk_q[r-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      fusion_pe #(.ACC_W(ACC_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .w_load_i (w_fire),
        .w_i      (ext_operand(w_data[(r*COLS+c)*8 +: 8], cfg_weight_width, cfg_s_weight)),
        .x_i      (xg[r][c]),
        .psum_i   (pg[r][c]),
        .x_o      (xg[r][c+1]),
        .psum_o   (pg[r+1][c])
      );
    end
  end

  // Column c finishes c cycles after column 0; delay the early ones to align.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    assign pg[0][c] = '0;
    if (c == COLS - 1) begin : g_direct
      assign out_psum_d[c*ACC_W +: ACC_W] = pg[ROWS][c];
    end else begin : g_delay
      logic [ACC_W-1:0] ds_q [COLS-1-c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < COLS - 1 - c; i++) ds_q[i] <= '0;
        end else if (en) begin
          ds_q[0] <= pg[ROWS][c];
          for (int i = 1; i < COLS - 1 - c; i++) ds_q[i] <= ds_q[i-1];
        end
      end
      assign out_psum_d[c*ACC_W +: ACC_W] = ds_q[COLS-2-c];
    end
  end

  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;

endmodule

// File: tb/tb_fusion_systolic_array.sv
// Self-checking bench for fusion_systolic_array (4x4, 32-bit sums) against an
// arithmetic matrix-vector model with per-job latched precision.
module tb_fusion_systolic_array;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ACC_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             cfg_in_width, cfg_weight_width;
  logic                   cfg_s_in, cfg_s_weight;
  logic                   w_valid, w_ready;
  logic [ROWS*COLS*8-1:0] w_data;
  logic                   in_valid, in_ready, in_last;
  logic [ROWS*8-1:0]      in_data;
  logic                   out_valid, out_ready, busy;
  logic [COLS*ACC_W-1:0]  out_psum;

  fusion_systolic_array #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int wm [ROWS][COLS];
  int m_iw;
  bit m_si;

  logic [COLS*ACC_W-1:0] exp_q[$];
  logic [COLS*ACC_W-1:0] got_q[$];
  int                    acc_cyc[$];
  int                    got_cyc[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(out_psum);
      got_cyc.push_back(cyc);
    end
  end

  function automatic int ext_ref(int b, int code, bit s);
    int bits;
    int v;
    bits = (code == 0) ? 2 : (code == 1) ? 4 : 8;
    v = b % (1 << bits);
    if (s && v >= (1 << (bits - 1))) v -= (1 << bits);
    return v;
  endfunction

  function automatic logic [COLS*ACC_W-1:0] model_psum(logic [ROWS*8-1:0] xd);
    logic [COLS*ACC_W-1:0] res;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < ROWS; r++) s += ext_ref(int'(xd[r*8 +: 8]), m_iw, m_si) * wm[r][c];
      res[c*ACC_W +: ACC_W] = s;
    end
    return res;
  endfunction

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
  endtask

  task automatic load_weights(input logic [ROWS*COLS*8-1:0] wd, input logic [1:0] iw,
                              input logic [1:0] ww, input bit si, input bit sw);
    bit ok;
    ok = 0;
    w_data = wd; cfg_in_width = iw; cfg_weight_width = ww; cfg_s_in = si; cfg_s_weight = sw;
    w_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (w_ready) ok = 1;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    // scramble the config inputs: they must not matter until the next load
    w_data = {$urandom, $urandom, $urandom, $urandom};
    cfg_in_width = 2'($urandom_range(0, 3)); cfg_weight_width = 2'($urandom_range(0, 3));
    cfg_s_in = 1'($urandom); cfg_s_weight = 1'($urandom);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL load_weights: w_ready never seen within 20 cycles (got 0, want 1)");
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          wm[r][c] = ext_ref(int'(wd[(r*COLS+c)*8 +: 8]), int'(ww), sw);
      m_iw = int'(iw);
      m_si = si;
    end
  endtask

  task automatic send_vec(input logic [ROWS*8-1:0] xd, input bit last);
    bit ok;
    ok = 0;
    in_data = xd; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        exp_q.push_back(model_psum(xd));
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_vec: in_ready never seen within 200 cycles (got 0, want 1)");
    end
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 400) begin
      @(posedge clk); #2;
      k++;
    end
    if (got_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_results: got %0d results, want %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (w_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_w_ready: got %b want 1", w_ready); end
    if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (out_psum !== '0)    begin n_bad++; $display("FAIL rst_out_psum: got %h want 0", out_psum); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
    if (w_ready !== 1'b1)   begin n_bad++; $display("FAIL post_rst_w_ready: got %b want 1", w_ready); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [ROWS*COLS*8-1:0] wd;
    logic [COLS*ACC_W-1:0]  want;
    clear_q();
    wd = '0;
    for (int r = 0; r < ROWS; r++) wd[(r*COLS+r)*8 +: 8] = 8'h01;
    load_weights(wd, 2'd2, 2'd2, 1'b1, 1'b1);
    send_vec(32'h04030201, 1'b1);
    wait_results(1);
    want = {32'd4, 32'd3, 32'd2, 32'd1};
    if (got_q.size() >= 1) begin
      n_cmp += 2;
      if (got_q[0] !== want) begin n_bad++; $display("FAIL identity_psum: got %h want %h", got_q[0], want); end
      if (got_cyc[0] - acc_cyc[0] != ROWS + COLS) begin
        n_bad++; $display("FAIL identity_latency: got %0d want %0d", got_cyc[0] - acc_cyc[0], ROWS + COLS);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL identity_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_extreme();
    logic [ACC_W-1:0] want;
    clear_q();
    want = -65024;
    load_weights({16{8'h7F}}, 2'd2, 2'd2, 1'b1, 1'b1);
    send_vec(32'h80808080, 1'b1);
    wait_results(1);
    if (got_q.size() >= 1)
      for (int c = 0; c < COLS; c++) begin
        n_cmp++;
        if (got_q[0][c*ACC_W +: ACC_W] !== want) begin
          n_bad++; $display("FAIL extreme_col%0d: got %0d want %0d", c, $signed(got_q[0][c*ACC_W +: ACC_W]), $signed(want));
        end
      end
  endtask

  task automatic test_narrow();
    logic [1:0]       codes [3];
    bit               sgn   [3];
    logic [ACC_W-1:0] want  [3];
    codes = '{2'd0, 2'd0, 2'd1};
    sgn   = '{1'b0, 1'b1, 1'b0};
    want  = '{32'd12, -32'sd4, 32'd60};
    for (int t = 0; t < 3; t++) begin
      clear_q();
      load_weights({16{8'h01}}, codes[t], codes[t], sgn[t], sgn[t]);
      send_vec(32'hFFFFFFFF, 1'b1);
      wait_results(1);
      if (got_q.size() >= 1)
        for (int c = 0; c < COLS; c++) begin
          n_cmp++;
          if (got_q[0][c*ACC_W +: ACC_W] !== want[t]) begin
            n_bad++; $display("FAIL narrow_case%0d_col%0d: got %0d want %0d", t, c,
                              $signed(got_q[0][c*ACC_W +: ACC_W]), $signed(want[t]));
          end
        end
    end
  endtask

  task automatic test_back_to_back();
    logic [COLS*ACC_W-1:0] held;
    clear_q();
    load_weights({$urandom, $urandom, $urandom, $urandom}, 2'd2, 2'd2, 1'b1, 1'b1);
    fork
      begin
        for (int i = 0; i < 10; i++) send_vec($urandom, i == 9);
      end
      begin
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 100);
        n_cmp++;
        if (!out_valid) begin n_bad++; $display("FAIL b2b_first_valid: got 0 want 1"); end
        @(posedge clk); #1 out_ready = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n_cmp += 3;
          if (i == 0) held = out_psum;
          else if (out_psum !== held) begin n_bad++; $display("FAIL b2b_stall_hold: got %h want %h", out_psum, held); end
          if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
          if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_valid: got %b want 1", out_valid); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_results(10);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 10) begin n_bad++; $display("FAIL b2b_count: got %0d want 10", got_q.size()); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    int k;
    clear_q();
    load_weights({$urandom, $urandom, $urandom, $urandom}, 2'd2, 2'd2, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_vec($urandom, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 50);
    n_cmp++;
    if (!out_valid) begin n_bad++; $display("FAIL rstmid_valid_before: got 0 want 1"); end
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    if (w_ready !== 1'b1)   begin n_bad++; $display("FAIL rstmid_w_ready: got %b want 1", w_ready); end
    if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    clear_q();
    load_weights({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom));
    send_vec($urandom, 1'b1);
    wait_results(1);
    repeat (15) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL rstmid_result: got %h want %h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_cfg_latch();
    clear_q();
    load_weights({$urandom, $urandom, $urandom, $urandom}, 2'd1, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cfg_in_width = (i == 0) ? 2'd2 : 2'($urandom_range(0, 3));
      cfg_s_in = (i == 0) ? 1'b0 : 1'($urandom);
      send_vec({8'h7C, 8'($urandom), 8'($urandom), 8'h9E}, i == 3);
    end
    wait_results(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL cfg_latch_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 3; j++) begin
      clear_q();
      load_weights({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom));
      fork
        begin
          for (int i = 0; i < 6; i++) send_vec($urandom, i == 5);
        end
        begin
          int k;
          k = 0;
          while (got_q.size() < 6 && k < 400) begin
            @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
            k++;
          end
          out_ready = 1'b1;
        end
      join
      wait_results(6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_job%0d_result%0d: got %h want %h", j, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cfg_in_width = 2'd0; cfg_weight_width = 2'd0; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
    w_valid = 1'b0; w_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_identity();
    test_extreme();
    test_narrow();
    test_back_to_back();
    test_reset_midstream();
    test_cfg_latch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fusion_systolic_array.md
FUSION_SYSTOLIC_ARRAY -- requirements
Module: fusion_systolic_array

Interface
REQ-001 Parameter ROWS, default 8: input-vector length, one array row per element.
REQ-002 Parameter COLS, default 8: output-vector length, one array column per element.
REQ-003 Parameter ACC_W, default 32: width of each output partial sum.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_in_width  in  2  input precision: 0=2b, 1=4b, 2=8b; 3 treated as 8b.
REQ-007 cfg_weight_width  in  2  weight precision, same encoding.
REQ-008 cfg_s_in / cfg_s_weight  in  1 each  1=signed operand, 0=unsigned.
REQ-009 w_valid / w_ready  in / out  1 each  weight-load handshake.
REQ-010 w_data  in  ROWS*COLS*8  weights; byte r*COLS+c (LSB first) = w[r][c].
REQ-011 in_valid / in_ready  in / out  1 each  input-vector handshake.
REQ-012 in_data  in  ROWS*8  input vector; byte r = x[r].
REQ-013 in_last  in  1  marks final vector of a job; sampled with the in handshake.
REQ-014 out_valid / out_ready  out / in  1 each  result handshake.
REQ-015 out_psum  out  COLS*ACC_W  result; slice c = psum[c].
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, STREAM, DRAIN; transfer = valid&&ready on the same edge.
REQ-018 IDLE: w_ready=1, in_ready=0; a w transfer latches all weights and all cfg_* signals and moves to STREAM.
REQ-019 cfg_* changes outside a w transfer are ignored until the next weight load.
REQ-020 STREAM: w_ready=0; in_ready=1 unless stalled; an in transfer with in_last=1 moves to DRAIN.
REQ-021 DRAIN: in_ready=0; returns to IDLE on the cycle the last result is transferred out.
REQ-022 Operand extension: value = low W bits of its byte, sign-extended if signed flag else zero-extended, to 9 bits.
REQ-023 psum[c] = sum over r of x[r]*w[r][c]; 9x9 signed products, sign-extended to ACC_W, sum wraps modulo 2^ACC_W.
REQ-024 Array is weight-stationary; row r input skewed r cycles, column c output deskewed so all COLS results appear together.
REQ-025 Latency: result of a vector accepted on cycle t asserts out_valid on cycle t+ROWS+COLS when no stall occurs.
REQ-026 Throughput: one vector per cycle; results in acceptance order, none dropped or duplicated.
REQ-027 Stall: out_valid&&!out_ready freezes the whole pipeline; in_ready=0; out_psum held stable.
REQ-028 Weights persist in IDLE; each job needs a new w transfer before inputs are accepted.

Reset
REQ-029 Reset takes effect immediately, including mid-job; in-flight results are discarded.
REQ-030 Reset values: state=IDLE, out_valid=0, out_psum=0, in_ready=0, w_ready=1, busy=0, weights=0, cfg=8b unsigned, pipeline valid bits=0.

Structure
REQ-031 Package fusion_sa_pkg holds the width-code constants, FSM state type and the operand-extension function.
REQ-032 One sub-module fusion_pe: weight register, extended multiply, add, forward of input and psum.

Verification (ROWS=COLS=4 unless noted)
REQ-033 Identity weights, 8b signed, x={1,2,3,4} -> psum={1,2,3,4} exactly 8 cycles after acceptance.
REQ-034 All weights 0x7F, x all 0x80, 8b signed -> every psum = 4*(-16256) = -65024.
REQ-035 Weights all 0x01, x all 0xFF: 2b unsigned -> psum=12; 2b signed -> psum=-4; 4b unsigned -> psum=60.
REQ-036 10 back-to-back vectors, out_ready low 5 cycles mid-stream -> in_ready=0 and out_psum stable while stalled; 10 ordered results; busy falls after the 10th.
REQ-037 Assert rst for 1 cycle during STREAM with 3 results in flight -> out_valid=0 same cycle, w_ready=1, no stale result after reload.
REQ-038 Change cfg_in_width during STREAM -> results follow the latched width.
